pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects load-use hazards and taken-branch squashes. Handles the data-memory req/ready handshake.
//  Drives per-register enable and flush strobes, a sticky memory-timeout flag and a stall-cycle counter.
// PARAMETERS
//  MAX_WAIT  16  max cycles in MEM_WAIT before timeout (>=2)
//  WAIT_W    5   width of wait counter; must hold MAX_WAIT
//  STALL_W   16  width of saturating stall-cycle counter
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        asynchronous reset, active-high
//  ID_rs, ID_rt    in   5 each   source regs of instruction in ID
//  EX_MemRead      in   1        instruction in EX is a load
//  EX_wreg         in   5        destination reg of instruction in EX
//  EX_br_taken     in   1        branch/jump in EX resolved taken
//  MEM_MemRead     in   1        load in MEM
//  MEM_MemWrite    in   1        store in MEM
//  dmem_ready      in   1        data memory completes access this cycle
//  dmem_req        out  1        data memory access request
//  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en   out  1 each   register load enables
//  IF_ID_flush, ID_EX_flush, MEM_WB_flush            out  1 each   load a bubble (all-zero controls)
//  mem_err         out  1        sticky: a memory access timed out
//  stall_cnt       out  STALL_W  cycles with PC_en=0, saturating
// BEHAVIOUR
//  - Reset (async, while rst=1): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0. All *_en=0, all *_flush=0, dmem_req=0.
//  - FSM state is registered. Strobes are combinational from state plus inputs, so they act the same cycle.
//  - mem_op = MEM_MemRead | MEM_MemWrite. dmem_req = mem_op in RUN, and 1 throughout MEM_WAIT.
//  - lu_haz = EX_MemRead & (EX_wreg!=0) & (EX_wreg==ID_rs | EX_wreg==ID_rt).
//  - Default in RUN (no event): all *_en=1, all *_flush=0.
//  - Priority per cycle: memory stall > branch squash > load-use stall.
//  - RUN, mem_op & !dmem_ready:
//      PC_en=IF_ID_en=ID_EX_en=EX_MEM_en=0; MEM_WB_en=1; MEM_WB_flush=1.
//      Next state MEM_WAIT, wait_cnt<=1. Branch and load-use are ignored; they are re-evaluated after the freeze.
//  - RUN, mem_op & dmem_ready: zero-wait access, no stall; proceed to the branch/load-use checks.
//  - RUN, EX_br_taken: all en=1; IF_ID_flush=1; ID_EX_flush=1. Load-use is ignored because the ID instruction is squashed.
//  - RUN, lu_haz only: PC_en=0, IF_ID_en=0, ID_EX_en=1 with ID_EX_flush=1; EX_MEM_en=MEM_WB_en=1.
//      Exactly 1 bubble per load-use hazard.
//  - MEM_WAIT, !dmem_ready & wait_cnt<MAX_WAIT: same strobes as stall entry; wait_cnt++.
//  - MEM_WAIT, dmem_ready: all en=1, no flush, next state RUN, wait_cnt<=0.
//      Branch and load-use are evaluated this cycle with the same priority as RUN.
//  - MEM_WAIT, !dmem_ready & wait_cnt==MAX_WAIT: timeout. mem_err<=1 and treat as ready (all en=1, next RUN).
//      mem_err clears only on rst.
//  - stall_cnt: increments on every non-reset cycle with PC_en=0 and holds at all-ones.
//  - rst asserted mid-MEM_WAIT: immediate return to RUN with outputs at reset values. Any pending access is abandoned.
// TESTING
//  - Reset: rst=1 mid-run -> same cycle: all en=0, dmem_req=0. After release, first cycle: all en=1, stall_cnt=0.
//  - Load-use: EX_MemRead=1, EX_wreg=5, ID_rt=5 for 1 cycle -> PC_en=0, IF_ID_en=0, ID_EX_flush=1 for exactly 1 cycle; stall_cnt=1.
//  - Load-use to $0: EX_wreg=0, ID_rs=0 -> no stall, all en=1.
//  - Memory wait: MEM_MemRead=1, dmem_ready low 3 cycles then high -> 3 cycles stalled with MEM_WB_flush=1,
//    dmem_req=1 for 4 cycles, resume on the 4th cycle; stall_cnt=3.
//  - Simultaneous: EX_br_taken=1 & lu_haz=1 -> IF_ID_flush=ID_EX_flush=1, PC_en=1. Add mem_op with !ready -> memory freeze wins, no flush.
//  - Timeout, MAX_WAIT=4: dmem_ready never asserted -> mem_err=1 on the 5th cycle after the request.
//    Pipeline resumes. mem_err stays 1 until rst.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
//   Bundles the hazard-detection inputs, the data-memory handshake and the
//   per-pipeline-register strobes that the stall controller exchanges with
//   the datapath.
//
//   master modport : the stall controller (reads hazard/memory status,
//                    drives enables, flushes, dmem_req and status)
//   slave modport  : the datapath side (drives hazard/memory status,
//                    consumes enables, flushes, dmem_req and status)
//
//   Signals
//     ID_rs, ID_rt      source registers of the instruction in ID
//     EX_MemRead        instruction in EX is a load
//     EX_wreg           destination register of the instruction in EX
//     EX_br_taken       branch/jump in EX resolved taken
//     MEM_MemRead       load in MEM
//     MEM_MemWrite      store in MEM
//     dmem_ready        data memory completes its access this cycle
//     dmem_req          data memory access request
//     PC_en .. MEM_WB_en                      register load enables
//     IF_ID_flush, ID_EX_flush, MEM_WB_flush  load a bubble
//     mem_err           sticky memory-timeout flag
//     stall_cnt         saturating count of cycles with PC_en low
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
   parameter int STALL_W = 16
);
   logic [4:0]         ID_rs;
   logic [4:0]         ID_rt;
   logic               EX_MemRead;
   logic [4:0]         EX_wreg;
   logic               EX_br_taken;
   logic               MEM_MemRead;
   logic               MEM_MemWrite;
   logic               dmem_ready;
   logic               dmem_req;
   logic               PC_en;
   logic               IF_ID_en;
   logic               ID_EX_en;
   logic               EX_MEM_en;
   logic               MEM_WB_en;
   logic               IF_ID_flush;
   logic               ID_EX_flush;
   logic               MEM_WB_flush;
   logic               mem_err;
   logic [STALL_W-1:0] stall_cnt;

   // The controller observes hazards and memory status and drives the strobes
   modport master (
      input  ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_br_taken,
      input  MEM_MemRead, MEM_MemWrite, dmem_ready,
      output dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
      output IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_err, stall_cnt
   );

   // The datapath reports hazards and memory status and obeys the strobes
   modport slave (
      output ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_br_taken,
      output MEM_MemRead, MEM_MemWrite, dmem_ready,
      input  dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
      input  IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_err, stall_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall/flush sequencer for the IF_ID, ID_EX, EX_MEM and MEM_WB
//   pipeline registers of a 5-stage pipeline. It freezes the pipeline while
//   the data memory is busy, squashes the two younger instructions on a taken
//   branch, and inserts one bubble for a load-use hazard. A sticky flag
//   records a memory access that never completed, and a saturating counter
//   tallies the cycles in which the PC was held.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   asynchronous reset, active-high
//     bus   master modport of pipe_stall_ctrl_if (hazard inputs, memory
//           handshake, register enables/flushes, mem_err, stall_cnt)
//
//   Parameters
//     MAX_WAIT  cycles allowed in MEM_WAIT before declaring a timeout (>=2)
//     WAIT_W    width of the wait counter, must hold MAX_WAIT
//     STALL_W   width of the saturating stall-cycle counter
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int WAIT_W   = 5,
   parameter int STALL_W  = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_stall_ctrl_if.master bus
);

   typedef enum logic {
      RUN,
      MEM_WAIT
   } state_t;

   localparam logic [WAIT_W-1:0] MaxWaitC = WAIT_W'(MAX_WAIT);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
   logic               memErr_q, memErr_d;
   logic [STALL_W-1:0] stallCnt_q, stallCnt_d;

   logic memOp;
   logic luHaz;
   logic memStall;
   logic dmemReq;
   logic pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
   logic ifIdFlush, idExFlush, memWbFlush;

   // A memory stage access is pending whenever MEM holds a load or a store.
   // A load-use hazard exists when the load in EX writes a real register
   // (never $0) that the instruction in ID wants to read.
   always_comb begin
      memOp = bus.MEM_MemRead | bus.MEM_MemWrite;
      luHaz = bus.EX_MemRead && (bus.EX_wreg != 5'd0) &&
              ((bus.EX_wreg == bus.ID_rs) || (bus.EX_wreg == bus.ID_rt));
   end

   // Next-state and strobe logic. The state only tells us whether we are
   // frozen on an outstanding memory access; everything else is decided from
   // this cycle's inputs so the strobes take effect in the same cycle.
   // Priority is memory freeze, then branch squash, then load-use bubble.
   // Leaving MEM_WAIT (ready or timed out) behaves exactly like a RUN cycle
   // with no memory stall, so branch and load-use get re-evaluated there.
   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      memErr_d   = memErr_q;
      memStall   = 1'b0;
      dmemReq    = 1'b0;
      pcEn       = 1'b1;
      ifIdEn     = 1'b1;
      idExEn     = 1'b1;
      exMemEn    = 1'b1;
      memWbEn    = 1'b1;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;
      memWbFlush = 1'b0;

      case (state_q)
         RUN: begin
            dmemReq = memOp;
            if (memOp && !bus.dmem_ready) begin
               memStall  = 1'b1;
               state_d   = MEM_WAIT;
               waitCnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            dmemReq = 1'b1;
            if (bus.dmem_ready) begin
               state_d   = RUN;
               waitCnt_d = '0;
            end else if (waitCnt_q < MaxWaitC) begin
               memStall  = 1'b1;
               waitCnt_d = waitCnt_q + 1'b1;
            end else begin
               memErr_d  = 1'b1;
               state_d   = RUN;
               waitCnt_d = '0;
            end
         end
         default: begin
            state_d   = RUN;
            waitCnt_d = '0;
         end
      endcase

      if (memStall) begin
         pcEn       = 1'b0;
         ifIdEn     = 1'b0;
         idExEn     = 1'b0;
         exMemEn    = 1'b0;
         memWbFlush = 1'b1;
      end else if (bus.EX_br_taken) begin
         ifIdFlush  = 1'b1;
         idExFlush  = 1'b1;
      end else if (luHaz) begin
         pcEn       = 1'b0;
         ifIdEn     = 1'b0;
         idExFlush  = 1'b1;
      end

      stallCnt_d = stallCnt_q;
      if (!pcEn && (stallCnt_q != '1)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   // State, wait counter, sticky error and stall counter. Reset drops any
   // outstanding access and returns straight to RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         memErr_q   <= 1'b0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         memErr_q   <= memErr_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   // The strobes are combinational, so they are forced low while reset is
   // held; otherwise the RUN defaults would leak out during reset.
   always_comb begin
      bus.dmem_req     = dmemReq    & ~rst;
      bus.PC_en        = pcEn       & ~rst;
      bus.IF_ID_en     = ifIdEn     & ~rst;
      bus.ID_EX_en     = idExEn     & ~rst;
      bus.EX_MEM_en    = exMemEn    & ~rst;
      bus.MEM_WB_en    = memWbEn    & ~rst;
      bus.IF_ID_flush  = ifIdFlush  & ~rst;
      bus.ID_EX_flush  = idExFlush  & ~rst;
      bus.MEM_WB_flush = memWbFlush & ~rst;
      bus.mem_err      = memErr_q;
      bus.stall_cnt    = stallCnt_q;
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Directed bench for pipe_stall_ctrl with a small MAX_WAIT and a narrow
//   stall counter so that timeout and saturation are reachable quickly.
//   A reference model describes the controller in terms of "how many cycles
//   has the current memory access been frozen" and is compared against the
//   DUT on every falling edge; literal expectations pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam int MAX_WAIT  = 4;
   localparam int WAIT_W    = 5;
   localparam int STALL_W   = 4;
   localparam int STALL_MAX = (1 << STALL_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   int       mFrozen = 0;
   bit       mErr    = 1'b0;
   int       mStall  = 0;
   logic [8:0] mExp;
   logic [8:0] cExp;
   logic [8:0] cGot;

   pipe_stall_ctrl_if #(.STALL_W(STALL_W)) bus();

   pipe_stall_ctrl #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W),
      .STALL_W  (STALL_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Expected strobes {dmem_req, PC_en, IF_ID_en, ID_EX_en, EX_MEM_en,
   // MEM_WB_en, IF_ID_flush, ID_EX_flush, MEM_WB_flush} for this cycle.
   // mFrozen counts cycles the current access has already spent frozen; a
   // fresh access freezes if memory is not ready, an ongoing one keeps
   // freezing until it has been frozen MAX_WAIT cycles.
   function automatic logic [8:0] expectStrobes();
      logic memOp;
      logic lu;
      logic freeze;
      logic req;
      if (rst) return 9'b0;
      memOp  = bus.MEM_MemRead | bus.MEM_MemWrite;
      lu     = bus.EX_MemRead && (bus.EX_wreg != 5'd0) &&
               ((bus.EX_wreg == bus.ID_rs) || (bus.EX_wreg == bus.ID_rt));
      freeze = !bus.dmem_ready && ((mFrozen > 0) ? (mFrozen < MAX_WAIT) : memOp);
      req    = (mFrozen > 0) || memOp;
      if (freeze)               return {req, 5'b00001, 3'b001};
      else if (bus.EX_br_taken) return {req, 5'b11111, 3'b110};
      else if (lu)              return {req, 5'b00111, 3'b010};
      else                      return {req, 5'b11111, 3'b000};
   endfunction

   // Model state advance: stalls counted whenever PC is held, frozen-cycle
   // count grows while frozen and a release without ready after MAX_WAIT
   // frozen cycles is a timeout.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mFrozen <= 0;
         mErr    <= 1'b0;
         mStall  <= 0;
      end else begin
         mExp = expectStrobes();
         if (!mExp[7] && (mStall < STALL_MAX)) mStall <= mStall + 1;
         if (mExp[0]) begin
            mFrozen <= mFrozen + 1;
         end else begin
            if ((mFrozen == MAX_WAIT) && !bus.dmem_ready) mErr <= 1'b1;
            mFrozen <= 0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model, away from the
   // active clock edge
   always @(negedge clk) begin
      cExp = expectStrobes();
      cGot = {bus.dmem_req, bus.PC_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en,
              bus.MEM_WB_en, bus.IF_ID_flush, bus.ID_EX_flush, bus.MEM_WB_flush};
      checks++;
      if (cGot !== cExp) begin
         failures++;
         $display("[TB] FAIL model_strobes t=%0t actual=%b required=%b", $time, cGot, cExp);
      end
      checks++;
      if (bus.stall_cnt !== STALL_W'(mStall)) begin
         failures++;
         $display("[TB] FAIL model_stall_cnt t=%0t actual=%0d required=%0d",
                  $time, bus.stall_cnt, mStall);
      end
      checks++;
      if (bus.mem_err !== mErr) begin
         failures++;
         $display("[TB] FAIL model_mem_err t=%0t actual=%b required=%b", $time, bus.mem_err, mErr);
      end
   end

   // Literal comparison against a hand-computed value
   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s t=%0t actual=%0d required=%0d", name, $time, got, exp);
      end
   endtask

   // Drive one cycle's worth of inputs just after the rising edge
   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input logic exRead, input logic [4:0] wreg,
                                input logic br, input logic memR, input logic memW,
                                input logic ready);
      @(posedge clk);
      #1;
      bus.ID_rs        = rs;
      bus.ID_rt        = rt;
      bus.EX_MemRead   = exRead;
      bus.EX_wreg      = wreg;
      bus.EX_br_taken  = br;
      bus.MEM_MemRead  = memR;
      bus.MEM_MemWrite = memW;
      bus.dmem_ready   = ready;
   endtask

   task automatic applyIdle();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Assert reset in the middle of a cycle, verify the strobes drop at
   // once, then release with idle inputs
   task automatic doReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_pc_en",     16'(bus.PC_en),     16'd0);
      checkOutput("rst_memwb_en",  16'(bus.MEM_WB_en), 16'd0);
      checkOutput("rst_dmem_req",  16'(bus.dmem_req),  16'd0);
      checkOutput("rst_stall_cnt", 16'(bus.stall_cnt), 16'd0);
      applyIdle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rel_pc_en",     16'(bus.PC_en),     16'd1);
      checkOutput("rel_memwb_en",  16'(bus.MEM_WB_en), 16'd1);
      checkOutput("rel_stall_cnt", 16'(bus.stall_cnt), 16'd0);
   endtask

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence
   initial begin
      bus.ID_rs        = 5'd0;
      bus.ID_rt        = 5'd0;
      bus.EX_MemRead   = 1'b0;
      bus.EX_wreg      = 5'd0;
      bus.EX_br_taken  = 1'b0;
      bus.MEM_MemRead  = 1'b0;
      bus.MEM_MemWrite = 1'b0;
      bus.dmem_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("first_pc_en",     16'(bus.PC_en),     16'd1);
      checkOutput("first_stall_cnt", 16'(bus.stall_cnt), 16'd0);

      // Load-use: one bubble, then the pipeline moves on
      applyStimulus(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("lu_pc_en",       16'(bus.PC_en),       16'd0);
      checkOutput("lu_if_id_en",    16'(bus.IF_ID_en),    16'd0);
      checkOutput("lu_id_ex_flush", 16'(bus.ID_EX_flush), 16'd1);
      applyIdle();
      @(negedge clk);
      checkOutput("lu_after_pc_en",     16'(bus.PC_en),       16'd1);
      checkOutput("lu_after_flush",     16'(bus.ID_EX_flush), 16'd0);
      checkOutput("lu_after_stall_cnt", 16'(bus.stall_cnt),   16'd1);

      // Load-use against $0 is not a hazard
      applyStimulus(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("lu0_pc_en", 16'(bus.PC_en),       16'd1);
      checkOutput("lu0_flush", 16'(bus.ID_EX_flush), 16'd0);

      // Memory wait: three frozen cycles, resume on the fourth
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("mw_pc_en",      16'(bus.PC_en),        16'd0);
         checkOutput("mw_memwb_fl",   16'(bus.MEM_WB_flush), 16'd1);
         checkOutput("mw_dmem_req",   16'(bus.dmem_req),     16'd1);
      end
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("mw_resume_pc_en",    16'(bus.PC_en),        16'd1);
      checkOutput("mw_resume_dmem_req", 16'(bus.dmem_req),     16'd1);
      checkOutput("mw_resume_memwb_fl", 16'(bus.MEM_WB_flush), 16'd0);
      applyIdle();
      @(negedge clk);
      checkOutput("mw_stall_cnt", 16'(bus.stall_cnt), 16'd3);
      checkOutput("mw_idle_req",  16'(bus.dmem_req),  16'd0);

      // Zero-wait store alongside a load-use hazard: hazard still bubbles
      applyStimulus(5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("zw_pc_en",    16'(bus.PC_en),    16'd0);
      checkOutput("zw_dmem_req", 16'(bus.dmem_req), 16'd1);

      // Branch and load-use together: branch squash wins
      applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("br_pc_en",    16'(bus.PC_en),       16'd1);
      checkOutput("br_ifid_fl",  16'(bus.IF_ID_flush), 16'd1);
      checkOutput("br_idex_fl",  16'(bus.ID_EX_flush), 16'd1);
      // Add a memory access that is not ready: freeze wins, no squash
      applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("brm_pc_en",   16'(bus.PC_en),        16'd0);
      checkOutput("brm_ifid_fl", 16'(bus.IF_ID_flush),  16'd0);
      checkOutput("brm_idex_fl", 16'(bus.ID_EX_flush),  16'd0);
      checkOutput("brm_memwb_fl",16'(bus.MEM_WB_flush), 16'd1);
      // Memory becomes ready: the branch is re-evaluated on the resume cycle
      applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("brr_pc_en",   16'(bus.PC_en),       16'd1);
      checkOutput("brr_ifid_fl", 16'(bus.IF_ID_flush), 16'd1);
      applyIdle();

      // Reset in the middle of a memory wait abandons the access
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      doReset();
      checkOutput("rstw_dmem_req", 16'(bus.dmem_req), 16'd0);

      // Timeout: memory never answers
      for (int i = 0; i < MAX_WAIT; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      applyIdle();
      @(negedge clk);
      checkOutput("to_release_pc_en", 16'(bus.PC_en),    16'd1);
      checkOutput("to_release_req",   16'(bus.dmem_req), 16'd1);
      checkOutput("to_release_err",   16'(bus.mem_err),  16'd0);
      applyIdle();
      @(negedge clk);
      checkOutput("to_err",       16'(bus.mem_err),   16'd1);
      checkOutput("to_stall_cnt", 16'(bus.stall_cnt), 16'd4);
      checkOutput("to_req_off",   16'(bus.dmem_req),  16'd0);

      // Hold a hazard long enough to saturate the counter; mem_err stays set
      for (int i = 0; i < 14; i++) begin
         applyStimulus(5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      applyIdle();
      @(negedge clk);
      checkOutput("sat_stall_cnt", 16'(bus.stall_cnt), 16'(STALL_MAX));
      checkOutput("sticky_err",    16'(bus.mem_err),   16'd1);

      // Only reset clears the error flag
      doReset();
      checkOutput("err_cleared", 16'(bus.mem_err), 16'd0);

      repeat (2) applyIdle();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
